// File: rtl/note_frame_scheduler_if.sv
// rtl/note_frame_scheduler_if.sv - chart memory fetch bus between the note scheduler and the chart store
interface note_frame_scheduler_if;
   logic        chart_req;
   logic [11:0] chart_addr;
   logic        chart_valid;
   logic [15:0] chart_time;
   logic [1:0]  chart_lane;
   logic        chart_last;

   modport master (
      output chart_req,
      output chart_addr,
      input  chart_valid,
      input  chart_time,
      input  chart_lane,
      input  chart_last
   );

   modport slave (
      input  chart_req,
      input  chart_addr,
      output chart_valid,
      output chart_time,
      output chart_lane,
      output chart_last
   );
endinterface

// File: rtl/note_frame_scheduler.sv
// rtl/note_frame_scheduler.sv - per-frame note advance/spawn scheduler with registered note pixel flag
module note_frame_scheduler #(
   parameter int LANES     = 4,
   parameter int SLOTS     = 8,
   parameter int SPEED     = 2,
   parameter int NOTE_H    = 16,
   parameter int LANE_X0   = 160,
   parameter int LANE_W    = 80,
   parameter int MISS_Y    = 480,
   parameter int MAX_SPAWN = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [9:0]             h_count,
   input  logic [9:0]             v_count,
   input  logic                   enable,
   input  logic                   clear,
   note_frame_scheduler_if.master chart,
   output logic                   note_on,
   output logic [1:0]             note_lane,
   output logic                   miss_pulse,
   output logic [1:0]             miss_lane,
   output logic                   overflow,
   output logic                   chart_done,
   output logic [15:0]            frame_cnt
);

   localparam int NS  = LANES * SLOTS;
   localparam int IW  = $clog2(NS);
   localparam int SW  = $clog2(SLOTS);
   localparam int SPW = $clog2(MAX_SPAWN + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADVANCE,
      S_FETCH,
      S_GAP,
      S_DONE
   } state_t;

   state_t                 state_q, state_d;
   logic [IW-1:0]          idx_q, idx_d;
   logic [SPW-1:0]         spawn_q, spawn_d;
   logic                   req_q, req_d;
   logic [11:0]            addr_q, addr_d;
   logic                   done_q, done_d;
   logic                   ovf_q, ovf_d;
   logic [15:0]            fcnt_q, fcnt_d;
   logic                   miss_q, miss_d;
   logic [1:0]             miss_lane_q, miss_lane_d;
   logic [NS-1:0]          valid_q, valid_d;
   logic [NS-1:0][9:0]     y_q, y_d;
   logic                   vline_q, vline_d;
   logic                   tick_q, tick_d;
   logic                   note_on_q, note_on_d;
   logic [1:0]             note_lane_q, note_lane_d;

   logic [10:0]            ny;
   logic                   free_found;
   logic [IW-1:0]          free_idx;

   assign chart.chart_req  = req_q;
   assign chart.chart_addr = addr_q;
   assign note_on          = note_on_q;
   assign note_lane        = note_lane_q;
   assign miss_pulse       = miss_q;
   assign miss_lane        = miss_lane_q;
   assign overflow         = ovf_q;
   assign chart_done       = done_q;
   assign frame_cnt        = fcnt_q;

   // Frame tick: single pulse on the first line of vertical blanking
   always_comb begin
      vline_d = (v_count == 10'd480);
      tick_d  = vline_d & ~vline_q;
   end

   // Sequencer: advance every slot, then pull due chart entries, then count the frame
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      spawn_d     = spawn_q;
      req_d       = req_q;
      addr_d      = addr_q;
      done_d      = done_q;
      ovf_d       = ovf_q;
      fcnt_d      = fcnt_q;
      miss_d      = 1'b0;
      miss_lane_d = 2'd0;
      valid_d     = valid_q;
      y_d         = y_q;
      ny          = 11'd0;
      free_found  = 1'b0;
      free_idx    = '0;

      case (state_q)
         S_IDLE: begin
            if (tick_q && enable) begin
               state_d = S_ADVANCE;
               idx_d   = '0;
            end
         end
         S_ADVANCE: begin
            if (valid_q[idx_q]) begin
               ny = {1'b0, y_q[idx_q]} + 11'(SPEED);
               if (ny >= 11'(MISS_Y)) begin
                  valid_d[idx_q] = 1'b0;
                  miss_d         = 1'b1;
                  miss_lane_d    = idx_q[IW-1:SW];
               end else begin
                  y_d[idx_q] = ny[9:0];
               end
            end
            idx_d = idx_q + IW'(1);
            if (idx_q == IW'(NS - 1)) begin
               spawn_d = '0;
               if (done_q) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_FETCH;
                  req_d   = 1'b1;
               end
            end
         end
         S_FETCH: begin
            if (chart.chart_valid) begin
               req_d = 1'b0;
               if (chart.chart_time > fcnt_q) begin
                  // Not due yet: keep the address so the entry is refetched next frame
                  state_d = S_DONE;
               end else begin
                  for (int s = 0; s < SLOTS; s++) begin
                     if (!free_found && !valid_q[{chart.chart_lane, SW'(s)}]) begin
                        free_found = 1'b1;
                        free_idx   = {chart.chart_lane, SW'(s)};
                     end
                  end
                  if (free_found) begin
                     valid_d[free_idx] = 1'b1;
                     y_d[free_idx]     = 10'd0;
                  end else begin
                     ovf_d = 1'b1;
                  end
                  addr_d  = addr_q + 12'd1;
                  spawn_d = spawn_q + SPW'(1);
                  if (chart.chart_last) begin
                     done_d  = 1'b1;
                     state_d = S_DONE;
                  end else if (spawn_q == SPW'(MAX_SPAWN - 1)) begin
                     state_d = S_DONE;
                  end else begin
                     state_d = S_GAP;
                  end
               end
            end
         end
         S_GAP: begin
            req_d   = 1'b1;
            state_d = S_FETCH;
         end
         S_DONE: begin
            fcnt_d  = fcnt_q + 16'd1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (clear) begin
         state_d     = S_IDLE;
         idx_d       = '0;
         spawn_d     = '0;
         req_d       = 1'b0;
         addr_d      = 12'd0;
         done_d      = 1'b0;
         ovf_d       = 1'b0;
         fcnt_d      = 16'd0;
         miss_d      = 1'b0;
         miss_lane_d = 2'd0;
         valid_d     = '0;
      end
   end

   // Pixel path: is the current (h,v) inside any valid note of the lane under h
   always_comb begin
      note_on_d   = 1'b0;
      note_lane_d = 2'd0;
      if (h_count < 10'd640 && v_count < 10'd480) begin
         for (int l = 0; l < LANES; l++) begin
            if (h_count >= 10'(LANE_X0 + l * LANE_W) &&
                h_count <  10'(LANE_X0 + (l + 1) * LANE_W)) begin
               for (int s = 0; s < SLOTS; s++) begin
                  if (valid_q[l * SLOTS + s] &&
                      v_count >= y_q[l * SLOTS + s] &&
                      {1'b0, v_count} < {1'b0, y_q[l * SLOTS + s]} + 11'(NOTE_H)) begin
                     note_on_d   = 1'b1;
                     note_lane_d = 2'(l);
                  end
               end
            end
         end
      end
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         spawn_q     <= '0;
         req_q       <= 1'b0;
         addr_q      <= 12'd0;
         done_q      <= 1'b0;
         ovf_q       <= 1'b0;
         fcnt_q      <= 16'd0;
         miss_q      <= 1'b0;
         miss_lane_q <= 2'd0;
         valid_q     <= '0;
         y_q         <= '0;
         vline_q     <= 1'b0;
         tick_q      <= 1'b0;
         note_on_q   <= 1'b0;
         note_lane_q <= 2'd0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         spawn_q     <= spawn_d;
         req_q       <= req_d;
         addr_q      <= addr_d;
         done_q      <= done_d;
         ovf_q       <= ovf_d;
         fcnt_q      <= fcnt_d;
         miss_q      <= miss_d;
         miss_lane_q <= miss_lane_d;
         valid_q     <= valid_d;
         y_q         <= y_d;
         vline_q     <= vline_d;
         tick_q      <= tick_d;
         note_on_q   <= note_on_d;
         note_lane_q <= note_lane_d;
      end
   end

endmodule
